// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared widths, increment constant and sequencer state encoding
package pc_sequencer_pkg;
  localparam int PC_W = 32;
  localparam int OFF_W = 8;
  localparam logic [PC_W-1:0] PC_INC = 32'd4;
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;
endpackage

// File: rtl/pc_sequencer_target_calc.sv
// pc_target_calc: combinational PC+4 and sign-extended word-offset branch/jump target
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0]  pc,
  input  logic [OFF_W-1:0] offset,
  output logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  target
);
  assign pc_plus4 = pc + PC_INC;
  assign target = pc_plus4 + {{(PC_W-OFF_W-2){offset[OFF_W-1]}}, offset, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register and next-PC sequencer with stall-held redirect.
// Define PC_BNE_EN to let the BNE input take part in the redirect decision.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'd0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             BUSYWAIT,
  input  logic             JUMP,
  input  logic             BRANCH,
  input  logic             BNE,
  input  logic             ZERO,
  input  logic [OFF_W-1:0] OFFSET,
  output logic [PC_W-1:0]  PC,
  output logic [PC_W-1:0]  PC_PLUS4,
  output logic             REDIRECTED
);
  state_t state;
  logic [PC_W-1:0] pend_reg;
  logic [PC_W-1:0] target;
  logic take;
  pc_target_calc u_calc (
    .pc      (PC),
    .offset  (OFFSET),
    .pc_plus4(PC_PLUS4),
    .target  (target)
  );
`ifdef PC_BNE_EN
  assign take = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO);
`else
  logic bne_unused;
  assign bne_unused = BNE;
  assign take = JUMP | (BRANCH & ZERO);
`endif
  // The first target captured during a stall wins; later requests are dropped.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      PC <= RESET_PC;
      REDIRECTED <= 1'b0;
      state <= RUN;
      pend_reg <= '0;
    end else if (state == HOLD) begin
      REDIRECTED <= !BUSYWAIT;
      if (!BUSYWAIT) begin
        PC <= pend_reg;
        state <= RUN;
      end
    end else if (!BUSYWAIT) begin
      PC <= take ? target : PC_PLUS4;
      REDIRECTED <= take;
    end else begin
      REDIRECTED <= 1'b0;
      if (take) begin
        pend_reg <= target;
        state <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed test-plan cases plus random stimulus against a behavioural model
module tb_pc_sequencer;
`ifdef PC_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n, busywait, jump, branch, bne, zero;
  logic [7:0] offset;
  logic [31:0] pc, pc_plus4;
  logic redirected;
  int checks = 0;
  int errors = 0;
  logic [31:0] mpc;
  logic mred;
  logic [31:0] pend_q[$];

  pc_sequencer dut (
    .CLK       (clk),
    .RESET     (rst_n),
    .BUSYWAIT  (busywait),
    .JUMP      (jump),
    .BRANCH    (branch),
    .BNE       (bne),
    .ZERO      (zero),
    .OFFSET    (offset),
    .PC        (pc),
    .PC_PLUS4  (pc_plus4),
    .REDIRECTED(redirected)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, advance the model from the spec rules, then compare after the edge.
  task automatic step(input bit r, input bit bw, input bit j, input bit b, input bit n,
                      input bit z, input logic [7:0] off);
    int so;
    bit tk;
    logic [31:0] tgt;
    rst_n = r; busywait = bw; jump = j; branch = b; bne = n; zero = z; offset = off;
    so = int'($signed(off));
    tgt = mpc + 32'd4 + 32'(so * 4);
    tk = j || (b && z) || (BNE_EN && n && !z);
    if (!r) begin
      mpc = 32'd0; mred = 1'b0; pend_q.delete();
    end else if (pend_q.size() != 0) begin
      if (!bw) begin mpc = pend_q.pop_front(); mred = 1'b1; end
      else mred = 1'b0;
    end else if (!bw) begin
      mred = tk;
      mpc = tk ? tgt : mpc + 32'd4;
    end else begin
      mred = 1'b0;
      if (tk) pend_q.push_back(tgt);
    end
    @(posedge clk);
    #1;
    check("pc", pc, mpc);
    check("pc_plus4", pc_plus4, mpc + 32'd4);
    check("redirected", {31'd0, redirected}, {31'd0, mred});
  endtask

  task automatic go_to(input int n);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    mpc = 32'd0; mred = 1'b0;
    go_to(0);
    check("reset_pc", pc, 32'd0);
    check("reset_pc4", pc_plus4, 32'd4);
    check("reset_red", {31'd0, redirected}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1, 0, 0, 0, 0, 0, 8'h00);
      check("seq_step", pc, 32'(4 * i));
    end
    go_to(2);
    step(1, 0, 1, 0, 0, 0, 8'h03);
    check("jump_fwd", pc, 32'd24);
    check("jump_red", {31'd0, redirected}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    check("red_clear", {31'd0, redirected}, 32'd0);
    go_to(2);
    step(1, 0, 1, 0, 0, 0, 8'hFE);
    check("jump_back", pc, 32'd4);
    go_to(4);
    step(1, 0, 0, 1, 0, 1, 8'h03);
    check("beq_taken", pc, 32'd32);
    go_to(4);
    step(1, 0, 0, 1, 0, 0, 8'h03);
    check("beq_not", pc, 32'd20);
    check("beq_not_red", {31'd0, redirected}, 32'd0);
    go_to(0);
    step(1, 0, 0, 0, 1, 0, 8'h02);
    check("bne", pc, BNE_EN ? 32'd12 : 32'd4);
    go_to(2);
    step(1, 0, 1, 1, 0, 1, 8'h01);
    check("jump_and_beq_red", {31'd0, redirected}, 32'd1);
    go_to(10);
    step(1, 1, 1, 0, 0, 0, 8'h01);
    check("stall1", pc, 32'd40);
    step(1, 1, 0, 0, 0, 0, 8'h05);
    check("stall2", pc, 32'd40);
    step(1, 1, 1, 0, 0, 0, 8'h05);
    check("stall3", pc, 32'd40);
    step(1, 0, 0, 0, 0, 0, 8'h05);
    check("stall_apply", pc, 32'd48);
    check("stall_red", {31'd0, redirected}, 32'd1);
    go_to(10);
    step(1, 1, 1, 0, 0, 0, 8'h07);
    step(0, 1, 0, 0, 0, 0, 8'h00);
    check("hold_reset", pc, 32'd0);
    step(1, 0, 0, 0, 0, 0, 8'h00);
    check("hold_reset_drop", pc, 32'd4);
    check("hold_reset_red", {31'd0, redirected}, 32'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 29) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'($urandom),
           8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC sequencer for the 8-bit single-cycle CPU. It owns the 32-bit PC, generates PC+4 and the branch/jump target, decides the redirect from control and ALU-zero inputs, and holds the PC while the memory hierarchy stalls. A redirect requested during a stall is captured and applied when the stall ends. It sits between the control unit/ALU and the instruction cache, driving the fetch address every cycle.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset
- CLK  input  1  system clock, rising-edge active
- RESET  input  1  synchronous, active-low reset
- BUSYWAIT  input  1  memory stall; high = PC must hold
- JUMP  input  1  unconditional jump for the current instruction
- BRANCH  input  1  beq for the current instruction
- BNE  input  1  bne for the current instruction (used only when PC_BNE_EN is defined)
- ZERO  input  1  ALU zero flag
- OFFSET  input  8  signed word offset from the instruction
- PC  output  32  current fetch address
- PC_PLUS4  output  32  PC + 4, combinational
- REDIRECTED  output  1  high for one cycle after a PC update that took a redirect

## Operation
- target = PC_PLUS4 + ({{22{OFFSET[7]}}, OFFSET, 2'b00}). Use 32-bit modular arithmetic. Wrap past 32'hFFFFFFFC is silent.
- take = JUMP | (BRANCH & ZERO) | (BNE & ~ZERO). The BNE term is present only with the macro.
- States:
  - RUN: the normal state.
  - HOLD: stalled, with a redirect pending.
- RUN, BUSYWAIT=0:
  - PC <= take ? target : PC_PLUS4.
  - REDIRECTED <= take.
- RUN, BUSYWAIT=1, take=1:
  - Latch target into pend_reg.
  - Move to HOLD.
  - PC holds.
  - REDIRECTED <= 0.
- RUN, BUSYWAIT=1, take=0:
  - PC holds.
  - REDIRECTED <= 0.
  - Stay in RUN.
- HOLD, BUSYWAIT=1:
  - PC holds.
  - pend_reg holds. New take/target values are ignored, so the first captured target wins.
- HOLD, BUSYWAIT=0:
  - PC <= pend_reg.
  - REDIRECTED <= 1.
  - Move to RUN. Current take/OFFSET inputs are ignored on this edge.
- Reset has priority over everything, including a stall or the HOLD state:
  - PC <= RESET_PC, REDIRECTED <= 0.
  - State <= RUN, pend_reg <= 0.
- Simultaneous JUMP and BRANCH: JUMP dominates. Both use the same target, so only the REDIRECTED value matters, and it is 1.

## Timing
- One PC update per rising CLK edge when not stalled. Decision-to-PC latency is one edge.
- PC_PLUS4 and target are combinational from PC/OFFSET. The registered PC has no extra delay.
- A redirect captured during a stall is applied on the first edge where BUSYWAIT=0 is sampled.
- REDIRECTED is registered. It is valid in the cycle after the update and clears on the next edge unless another redirect occurs.
- Reset outputs: PC=RESET_PC, PC_PLUS4=RESET_PC+4, REDIRECTED=0.

## Configuration
- PC_BNE_EN defined:
  - The BNE input participates in take.
- PC_BNE_EN undefined:
  - The BNE port still exists but is ignored.
  - take = JUMP | (BRANCH & ZERO).
  - A BNE instruction advances to PC+4.

## Structure
- Shared package: the state encoding (RUN, HOLD), the PC width (32), the offset width (8) and the PC increment constant (4).
- One sub-module, pc_target_calc: combinational PC_PLUS4 and sign-extended, shifted target. Instantiated once.
- Everything else (state register, pend_reg, PC register, take logic) lives in pc_sequencer.

## Test plan
- Reset with RESET=0 for 2 cycles, then release with no control active -> PC=0, REDIRECTED=0, then PC steps 0, 4, 8, 12 on successive edges.
- At PC=8, JUMP=1 with OFFSET=8'h03 -> next PC=24 (8+4+12), REDIRECTED=1 for one cycle. Repeat at PC=8 with OFFSET=8'hFE -> next PC=4.
- At PC=16, BRANCH=1: with ZERO=1 -> PC=20+OFFSET*4. With ZERO=0 -> PC=20, REDIRECTED=0.
- With PC_BNE_EN, at PC=0, BNE=1, ZERO=0, OFFSET=2 -> PC=12. Without the macro, the same stimulus -> PC=4.
- At PC=40, BUSYWAIT=1 for 3 cycles with JUMP=1 and OFFSET=1 in the first stalled cycle; then JUMP=0, OFFSET=5 while still stalled -> PC holds 40 for all 3 stall cycles, becomes 48 on the first non-stall edge, REDIRECTED=1.
- In HOLD with a pending target, assert RESET=0 -> PC=RESET_PC and state RUN. After release, the pending target is never applied.
